// File: rtl/riscv_dec_pkg.sv
// RV32I decode-stage shared definitions: opcodes, op_class bit positions and the decoded entry.
package riscv_dec_pkg;

    localparam int unsigned XLEN_C   = 32;
    localparam int unsigned REG_AW_C = 5;
    localparam int unsigned NCLASS   = 11;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam int unsigned CL_LOAD    = 0;
    localparam int unsigned CL_OPIMM   = 1;
    localparam int unsigned CL_AUIPC   = 2;
    localparam int unsigned CL_STORE   = 3;
    localparam int unsigned CL_OP      = 4;
    localparam int unsigned CL_LUI     = 5;
    localparam int unsigned CL_BRANCH  = 6;
    localparam int unsigned CL_JALR    = 7;
    localparam int unsigned CL_JAL     = 8;
    localparam int unsigned CL_SYSTEM  = 9;
    localparam int unsigned CL_MISCMEM = 10;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [REG_AW_C-1:0] rs1;
        logic [REG_AW_C-1:0] rs2;
        logic [REG_AW_C-1:0] rd;
        logic                rs1_en;
        logic                rs2_en;
        logic                rd_en;
        logic                imm_en;
        logic                pc_en;
        logic [XLEN_C-1:0]   imm;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [NCLASS-1:0]   op_class;
        logic                illegal;
        logic                is_muldiv;
        logic [XLEN_C-1:0]   pc;
    } dec_entry_t;

endpackage

// File: rtl/rv_inst_decoder.sv
// Combinational RV32I instruction decoder: ir/pc -> decoded entry.
// Optional RV32M recognition is enabled by defining DEC_RV32M_EN.
module rv_inst_decoder
    import riscv_dec_pkg::*;
(
    input  logic [31:0]       ir,
    input  logic [XLEN_C-1:0] pc,
    output dec_entry_t        entry_c
);

    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [NCLASS-1:0]  cls;
    logic               illegal;
    logic               muldiv;
    logic [XLEN_C-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc = ir[6:0];
    assign f3  = ir[14:12];
    assign f7  = ir[31:25];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // Opcode classification; unlisted opcodes (including ir[1:0]!=11) are illegal
    always_comb begin
        cls     = '0;
        illegal = 1'b0;
        muldiv  = 1'b0;
        case (opc)
            OPC_LOAD:    cls[CL_LOAD]    = 1'b1;
            OPC_MISCMEM: cls[CL_MISCMEM] = 1'b1;
            OPC_OPIMM:   cls[CL_OPIMM]   = 1'b1;
            OPC_AUIPC:   cls[CL_AUIPC]   = 1'b1;
            OPC_STORE:   cls[CL_STORE]   = 1'b1;
            OPC_LUI:     cls[CL_LUI]     = 1'b1;
            OPC_BRANCH:  cls[CL_BRANCH]  = 1'b1;
            OPC_JAL:     cls[CL_JAL]     = 1'b1;
            OPC_SYSTEM:  cls[CL_SYSTEM]  = 1'b1;
            OPC_JALR: begin
                if (f3 == 3'b000) cls[CL_JALR] = 1'b1;
                else              illegal      = 1'b1;
            end
            OPC_OP: begin
                if (f7 == FUNCT7_MULDIV) begin
`ifdef DEC_RV32M_EN
                    cls[CL_OP] = 1'b1;
                    muldiv     = 1'b1;
`else
                    illegal    = 1'b1;
`endif
                end else begin
                    cls[CL_OP] = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    // Operand enables, register fields and immediate selection from the class vector
    always_comb begin
        entry_c           = '0;
        entry_c.rs1_en    = cls[CL_JALR] | cls[CL_BRANCH] | cls[CL_LOAD] | cls[CL_STORE]
                          | cls[CL_OP] | cls[CL_OPIMM];
        entry_c.rs2_en    = cls[CL_BRANCH] | cls[CL_STORE] | cls[CL_OP];
        entry_c.rd_en     = (cls[CL_LUI] | cls[CL_AUIPC] | cls[CL_JALR] | cls[CL_JAL]
                          | cls[CL_LOAD] | cls[CL_OP] | cls[CL_OPIMM]) && (ir[11:7] != 5'd0);
        entry_c.pc_en     = cls[CL_JAL] | cls[CL_BRANCH] | cls[CL_AUIPC];
        entry_c.imm_en    = (cls != '0) && !cls[CL_OP] && !cls[CL_MISCMEM];
        entry_c.rs1       = entry_c.rs1_en ? ir[19:15] : 5'd0;
        entry_c.rs2       = entry_c.rs2_en ? ir[24:20] : 5'd0;
        entry_c.rd        = entry_c.rd_en  ? ir[11:7]  : 5'd0;
        if (cls[CL_JALR] | cls[CL_LOAD] | cls[CL_OPIMM] | cls[CL_SYSTEM]) entry_c.imm = imm_i;
        else if (cls[CL_STORE])                                          entry_c.imm = imm_s;
        else if (cls[CL_BRANCH])                                         entry_c.imm = imm_b;
        else if (cls[CL_LUI] | cls[CL_AUIPC])                            entry_c.imm = imm_u;
        else if (cls[CL_JAL])                                            entry_c.imm = imm_j;
        entry_c.funct3    = f3;
        entry_c.funct7    = f7;
        entry_c.op_class  = cls;
        entry_c.illegal   = illegal;
        entry_c.is_muldiv = muldiv;
        entry_c.pc        = pc;
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: decodes fetch input and buffers DEPTH decoded entries with valid/ready on
// both sides and a flush that drops everything. RV32M via DEC_RV32M_EN (see rv_inst_decoder).
module decode_stage_pipe
    import riscv_dec_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       ir,
    input  logic [XLEN-1:0]   pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd,
    output logic              rs1_en,
    output logic              rs2_en,
    output logic              rd_en,
    output logic              imm_en,
    output logic              pc_en,
    output logic [XLEN-1:0]   imm,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [10:0]       op_class,
    output logic              illegal,
    output logic              is_muldiv,
    output logic [XLEN-1:0]   pc_out
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    dec_entry_t          dec_c;
    dec_entry_t          head_c;
    dec_entry_t          mem_q [DEPTH];
    dec_entry_t          mem_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                push_c, pop_c, empty_c;

    rv_inst_decoder u_dec (
        .ir      (ir),
        .pc      (XLEN_C'(pc)),
        .entry_c (dec_c)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_c  = (count_q == '0);
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign push_c   = in_valid && in_ready && !flush;
    assign pop_c    = !empty_c && out_ready && !flush;

    // Pointer, count and storage update; flush clears the buffer ahead of push/pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_c) begin
                mem_d[tail_q] = dec_c;
                tail_d        = ptr_inc(tail_q);
            end
            if (pop_c) head_d = ptr_inc(head_q);
            if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
            else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    // Head entry presented to execute; all-zero when nothing is buffered
    always_comb begin
        head_c = '0;
        if (!empty_c) head_c = mem_q[head_q];
    end

    assign out_valid = !empty_c;
    assign rs1       = REG_AW'(head_c.rs1);
    assign rs2       = REG_AW'(head_c.rs2);
    assign rd        = REG_AW'(head_c.rd);
    assign rs1_en    = head_c.rs1_en;
    assign rs2_en    = head_c.rs2_en;
    assign rd_en     = head_c.rd_en;
    assign imm_en    = head_c.imm_en;
    assign pc_en     = head_c.pc_en;
    assign imm       = XLEN'(head_c.imm);
    assign funct3    = head_c.funct3;
    assign funct7    = head_c.funct7;
    assign op_class  = head_c.op_class;
    assign illegal   = head_c.illegal;
    assign is_muldiv = head_c.is_muldiv;
    assign pc_out    = XLEN'(head_c.pc);

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: reference decoder feeding a scoreboard queue,
// plus directed field checks on the example instructions.
module tb_decode_stage_pipe;
    import riscv_dec_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] ir, pc;
    logic        in_ready, out_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_en, rs2_en, rd_en, imm_en, pc_en;
    logic [31:0] imm, pc_out;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [10:0] op_class;
    logic        illegal, is_muldiv;

    dec_entry_t  obs_e;
    dec_entry_t  exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        last_acc = 1'b0;

    decode_stage_pipe #(.XLEN(32), .DEPTH(DEPTH), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ir(ir), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rs1_en(rs1_en), .rs2_en(rs2_en), .rd_en(rd_en),
        .imm_en(imm_en), .pc_en(pc_en), .imm(imm), .funct3(funct3), .funct7(funct7),
        .op_class(op_class), .illegal(illegal), .is_muldiv(is_muldiv), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    always_comb begin
        obs_e = '{rs1: rs1, rs2: rs2, rd: rd, rs1_en: rs1_en, rs2_en: rs2_en, rd_en: rd_en,
                  imm_en: imm_en, pc_en: pc_en, imm: imm, funct3: funct3, funct7: funct7,
                  op_class: op_class, illegal: illegal, is_muldiv: is_muldiv, pc: pc_out};
    end

    // Reference decoder, organised per opcode rather than per enable
    function automatic dec_entry_t ref_dec(input logic [31:0] i, input logic [31:0] p);
        dec_entry_t e;
        logic a, b, d, m, c, legal;
        int   k;
        logic [31:0] v;
        e = '0; a = 0; b = 0; d = 0; m = 0; c = 0; legal = 1; k = 0; v = 0;
        e.funct3 = i[14:12];
        e.funct7 = i[31:25];
        e.pc     = p;
        case (i[6:0])
            7'h03: begin k = 0;  a = 1; d = 1; m = 1; v = {{20{i[31]}}, i[31:20]}; end
            7'h13: begin k = 1;  a = 1; d = 1; m = 1; v = {{20{i[31]}}, i[31:20]}; end
            7'h17: begin k = 2;  d = 1; c = 1; m = 1; v = {i[31:12], 12'h000}; end
            7'h23: begin k = 3;  a = 1; b = 1; m = 1; v = {{20{i[31]}}, i[31:25], i[11:7]}; end
            7'h33: begin
                k = 4; a = 1; b = 1; d = 1;
                if (i[31:25] == 7'd1) begin
`ifdef DEC_RV32M_EN
                    e.is_muldiv = 1'b1;
`else
                    legal = 0;
`endif
                end
            end
            7'h37: begin k = 5;  d = 1; m = 1; v = {i[31:12], 12'h000}; end
            7'h63: begin k = 6;  a = 1; b = 1; c = 1; m = 1;
                         v = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; end
            7'h67: begin k = 7;  a = 1; d = 1; m = 1; v = {{20{i[31]}}, i[31:20]};
                         if (i[14:12] != 3'd0) legal = 0; end
            7'h6F: begin k = 8;  d = 1; c = 1; m = 1;
                         v = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
            7'h73: begin k = 9;  m = 1; v = {{20{i[31]}}, i[31:20]}; end
            7'h0F: begin k = 10; end
            default: legal = 0;
        endcase
        if (!legal) begin
            e.illegal   = 1'b1;
            e.is_muldiv = 1'b0;
            return e;
        end
        d = d && (i[11:7] != 5'd0);
        e.op_class[k] = 1'b1;
        e.rs1_en = a; e.rs2_en = b; e.rd_en = d; e.imm_en = m; e.pc_en = c;
        e.rs1 = a ? i[19:15] : 5'd0;
        e.rs2 = b ? i[24:20] : 5'd0;
        e.rd  = d ? i[11:7]  : 5'd0;
        e.imm = v;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One cycle: check head and flags at negedge, update scoreboard, step to posedge+1
    task automatic tick();
        @(negedge clk);
        chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
        chk("in_ready",  128'(in_ready),  128'(exp_q.size() < DEPTH));
        if (out_valid && exp_q.size() != 0) chk("head_entry", 128'(obs_e), 128'(exp_q[0]));
        last_acc = in_valid && in_ready && !flush;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (last_acc) exp_q.push_back(ref_dec(ir, pc));
        end
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until accepted (bounded)
    task automatic send(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1; ir = i; pc = p;
        last_acc = 1'b0;
        for (int n = 0; n < 20 && !last_acc; n++) tick();
        chk("accept_in_time", 128'(last_acc), 128'(1'b1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [6:0]  ops [12];
        logic [31:0] r;
        ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h0F, 7'h7F};
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ir = '0; pc = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_in_ready",  128'(in_ready),  128'(1'b1));
        chk("rst_data",      128'(obs_e),     128'(0));

        // addi x1,x2,5
        send(32'h00510093, 32'h100);
        chk("addi_valid", 128'(out_valid), 128'(1'b1));
        chk("addi_class", 128'(op_class),  128'(11'h002));
        chk("addi_rs1",   128'(rs1),       128'(5'd2));
        chk("addi_rd",    128'(rd),        128'(5'd1));
        chk("addi_imm",   128'(imm),       128'(32'd5));
        chk("addi_rs2en", 128'(rs2_en),    128'(1'b0));
        chk("addi_pc",    128'(pc_out),    128'(32'h100));
        drain();

        // beq x1,x2,-4
        send(32'hFE208EE3, 32'h104);
        chk("beq_class", 128'(op_class), 128'(11'h040));
        chk("beq_imm",   128'(imm),      128'(32'hFFFFFFFC));
        chk("beq_en",    128'({pc_en, rs2_en, rd_en}), 128'(3'b110));
        drain();

        // Back-pressure: three inputs against a stalled consumer
        in_valid = 1'b1; ir = 32'h00100113; pc = 32'h200; tick();
        ir = 32'h00200193; pc = 32'h204; tick();
        ir = 32'h00300213; pc = 32'h208; tick();
        chk("full_in_ready",  128'(in_ready),     128'(1'b0));
        chk("full_count",     128'(exp_q.size()), 128'(2));
        chk("full_head_pc",   128'(pc_out),       128'(32'h200));
        out_ready = 1'b1;
        last_acc = 1'b0;
        for (int n = 0; n < 20 && !last_acc; n++) tick();
        chk("third_accepted", 128'(last_acc), 128'(1'b1));
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_drained", 128'(out_valid), 128'(1'b0));
        out_ready = 1'b0;

        // Flush with a concurrent valid input
        send(32'h00A00513, 32'h300);
        send(32'h00B00593, 32'h304);
        flush = 1'b1; in_valid = 1'b1; ir = 32'h00C00613; pc = 32'h308;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'(1'b0));
        chk("flush_in_ready",  128'(in_ready),  128'(1'b1));
        repeat (2) tick();

        // Illegal all-zero word, then FENCE
        send(32'h00000000, 32'h400);
        chk("ill_flag",  128'(illegal),  128'(1'b1));
        chk("ill_class", 128'(op_class), 128'(11'h000));
        chk("ill_en",    128'({rs1_en, rs2_en, rd_en, imm_en, pc_en}), 128'(5'b0));
        chk("ill_valid", 128'(out_valid), 128'(1'b1));
        drain();
        send(32'h0000100F, 32'h404);
        chk("fence_class", 128'(op_class), 128'(11'h400));
        chk("fence_legal", 128'(illegal),  128'(1'b0));
        drain();

        // mul x0,x1,x2
        send(32'h02208033, 32'h408);
`ifdef DEC_RV32M_EN
        chk("mul_muldiv", 128'(is_muldiv), 128'(1'b1));
        chk("mul_rd_en",  128'(rd_en),     128'(1'b0));
        chk("mul_class",  128'(op_class),  128'(11'h010));
`else
        chk("mul_illegal", 128'(illegal),   128'(1'b1));
        chk("mul_muldiv",  128'(is_muldiv), 128'(1'b0));
`endif
        drain();

        // Reset with entries buffered
        send(32'h00100093, 32'h500);
        send(32'h00200093, 32'h504);
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_valid", 128'(out_valid), 128'(1'b0));
        chk("midrst_data",  128'(obs_e),     128'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // Random traffic with random back-pressure and occasional flush
        for (int n = 0; n < 400; n++) begin
            r         = $urandom();
            ir        = {r[31:7], ops[$urandom_range(0, 11)]};
            pc        = $urandom() & 32'hFFFF_FFFC;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0;
        drain();
        chk("final_empty", 128'(out_valid), 128'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
